// File: rtl/rob_multi_if.sv
// rob_multi_if: bundles the dispatch, CDB, commit, read-port, disambiguation
// and status signals of the reorder buffer. "master" is the pipeline side
// driving requests, "slave" is the reorder buffer itself.
`ifndef XLEN
`define XLEN 32
`endif

interface rob_multi_if #(
  parameter int ROB_SIZE  = 8,
  parameter int CDB_PORTS = 2
);
  localparam int TAG_W = $clog2(ROB_SIZE);
  localparam int XW    = `XLEN;

  // dispatch / allocation
  logic                      alloc_enable;
  logic                      alloc_wr_mem;
  logic [4:0]                alloc_dest_reg;
  logic [XW-1:0]             alloc_value_in;
  logic                      alloc_value_in_valid;
  logic [TAG_W-1:0]          alloc_store_dep;
  // completion broadcast
  logic [CDB_PORTS-1:0]      cdb_valid;
  logic [CDB_PORTS*TAG_W-1:0] cdb_tag;
  logic [CDB_PORTS*XW-1:0]   cdb_value;
  // commit / flush
  logic                      commit_enable;
  logic                      flush;
  // operand read port
  logic [TAG_W-1:0]          read_rob_tag;
  logic [XW-1:0]             read_value;
  logic                      read_ready;
  // load disambiguation / forwarding
  logic [XW-1:0]             load_address;
  logic [TAG_W-1:0]          load_rob_tag;
  logic                      pending_stores;
  logic                      fwd_hit;
  logic [XW-1:0]             fwd_value;
  // status and head of buffer
  logic                      full;
  logic                      empty;
  logic [TAG_W:0]            count;
  logic [TAG_W-1:0]          alloc_slot;
  logic                      head_valid;
  logic                      head_ready;
  logic                      head_wr_mem;
  logic [4:0]                head_dest_reg;
  logic [XW-1:0]             head_value;
  logic [XW-1:0]             head_address;
  logic [TAG_W-1:0]          head_tag;

  modport master (
    output alloc_enable, alloc_wr_mem, alloc_dest_reg, alloc_value_in,
           alloc_value_in_valid, alloc_store_dep, cdb_valid, cdb_tag, cdb_value,
           commit_enable, flush, read_rob_tag, load_address, load_rob_tag,
    input  read_value, read_ready, pending_stores, fwd_hit, fwd_value, full,
           empty, count, alloc_slot, head_valid, head_ready, head_wr_mem,
           head_dest_reg, head_value, head_address, head_tag
  );

  modport slave (
    input  alloc_enable, alloc_wr_mem, alloc_dest_reg, alloc_value_in,
           alloc_value_in_valid, alloc_store_dep, cdb_valid, cdb_tag, cdb_value,
           commit_enable, flush, read_rob_tag, load_address, load_rob_tag,
    output read_value, read_ready, pending_stores, fwd_hit, fwd_value, full,
           empty, count, alloc_slot, head_valid, head_ready, head_wr_mem,
           head_dest_reg, head_value, head_address, head_tag
  );
endinterface

// File: rtl/rob_multi.sv
// rob_multi: circular reorder buffer with several CDB write ports, commit and
// flush handshakes, and older-store disambiguation for loads.
// Define ROB_STORE_FWD_EN to enable store-to-load forwarding; without it
// fwd_hit/fwd_value are tied to zero.
`ifndef XLEN
`define XLEN 32
`endif

module rob_multi #(
  parameter int ROB_SIZE  = 8,
  parameter int CDB_PORTS = 2
) (
  input logic        clock,
  input logic        reset,
  rob_multi_if.slave bus
);
  localparam int TAG_W = $clog2(ROB_SIZE);
  localparam int CNT_W = TAG_W + 1;
  localparam int XW    = `XLEN;

  logic [ROB_SIZE-1:0] valid_q, valid_d, wr_mem_q, wr_mem_d;
  logic [ROB_SIZE-1:0] vrdy_q, vrdy_d, ardy_q, ardy_d;
  logic [4:0]          dest_q  [ROB_SIZE];
  logic [4:0]          dest_d  [ROB_SIZE];
  logic [XW-1:0]       value_q [ROB_SIZE];
  logic [XW-1:0]       value_d [ROB_SIZE];
  logic [XW-1:0]       addr_q  [ROB_SIZE];
  logic [XW-1:0]       addr_d  [ROB_SIZE];
  logic [TAG_W-1:0]    dep_q   [ROB_SIZE];
  logic [TAG_W-1:0]    dep_d   [ROB_SIZE];
  logic [TAG_W-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]    count_q, count_d;

  // Unpack the flat CDB buses into per-port views.
  logic [TAG_W-1:0] cdb_tag_w [CDB_PORTS];
  logic [XW-1:0]    cdb_val_w [CDB_PORTS];
  genvar gi;
  generate
    for (gi = 0; gi < CDB_PORTS; gi++) begin : g_cdb
      assign cdb_tag_w[gi] = bus.cdb_tag[gi*TAG_W +: TAG_W];
      assign cdb_val_w[gi] = bus.cdb_value[gi*XW +: XW];
    end
  endgenerate

  logic          full_w, head_ready_w, alloc_fire, commit_fire;
  logic          byp_hit;
  logic [XW-1:0] byp_val;

  // Fullness uses registered count, so a same-cycle commit never frees a slot.
  assign full_w       = (count_q == CNT_W'(ROB_SIZE));
  assign head_ready_w = valid_q[head_q] & vrdy_q[head_q] & ardy_q[head_q];
  assign alloc_fire   = bus.alloc_enable & ~full_w & ~bus.flush;
  assign commit_fire  = bus.commit_enable & head_ready_w & ~bus.flush;

  // Store-data bypass: catch the producer's broadcast in the allocation cycle.
  always_comb begin
    byp_hit = 1'b0;
    byp_val = '0;
    for (int p = 0; p < CDB_PORTS; p++) begin
      if (bus.cdb_valid[p] && cdb_tag_w[p] == bus.alloc_store_dep) begin
        byp_hit = 1'b1;
        byp_val = cdb_val_w[p];
      end
    end
  end

  // Next state: CDB writes, then commit, then allocation; flush overrides all.
  always_comb begin
    valid_d = valid_q;
    wr_mem_d = wr_mem_q;
    vrdy_d  = vrdy_q;
    ardy_d  = ardy_q;
    dest_d  = dest_q;
    value_d = value_q;
    addr_d  = addr_q;
    dep_d   = dep_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    // Ascending port order lets the highest port win on duplicate tags.
    for (int e = 0; e < ROB_SIZE; e++) begin
      if (valid_q[e]) begin
        for (int p = 0; p < CDB_PORTS; p++) begin
          if (bus.cdb_valid[p]) begin
            if (cdb_tag_w[p] == TAG_W'(e)) begin
              if (wr_mem_q[e]) begin
                addr_d[e] = cdb_val_w[p];
                ardy_d[e] = 1'b1;
              end else begin
                value_d[e] = cdb_val_w[p];
                vrdy_d[e]  = 1'b1;
              end
            end
            if (wr_mem_q[e] && !vrdy_q[e] && cdb_tag_w[p] == dep_q[e]) begin
              value_d[e] = cdb_val_w[p];
              vrdy_d[e]  = 1'b1;
            end
          end
        end
      end
    end
    if (commit_fire) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end
    if (alloc_fire) begin
      valid_d[tail_q]  = 1'b1;
      wr_mem_d[tail_q] = bus.alloc_wr_mem;
      dest_d[tail_q]   = bus.alloc_dest_reg;
      dep_d[tail_q]    = bus.alloc_store_dep;
      addr_d[tail_q]   = '0;
      if (bus.alloc_wr_mem) begin
        vrdy_d[tail_q]  = bus.alloc_value_in_valid | byp_hit;
        value_d[tail_q] = bus.alloc_value_in_valid ? bus.alloc_value_in :
                          (byp_hit ? byp_val : '0);
        ardy_d[tail_q]  = 1'b0;
      end else begin
        vrdy_d[tail_q]  = 1'b0;
        value_d[tail_q] = '0;
        ardy_d[tail_q]  = 1'b1;
      end
      tail_d = tail_q + 1'b1;
    end
    count_d = count_q + CNT_W'(alloc_fire) - CNT_W'(commit_fire);
    if (bus.flush) begin
      valid_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q  <= '0;
      wr_mem_q <= '0;
      vrdy_q   <= '0;
      ardy_q   <= '0;
      dest_q   <= '{default: '0};
      value_q  <= '{default: '0};
      addr_q   <= '{default: '0};
      dep_q    <= '{default: '0};
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      wr_mem_q <= wr_mem_d;
      vrdy_q   <= vrdy_d;
      ardy_q   <= ardy_d;
      dest_q   <= dest_d;
      value_q  <= value_d;
      addr_q   <= addr_d;
      dep_q    <= dep_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
    end
  end

  // Status, head and read-port outputs straight from registered state.
  assign bus.full          = full_w;
  assign bus.empty         = (count_q == '0);
  assign bus.count         = count_q;
  assign bus.alloc_slot    = tail_q;
  assign bus.head_tag      = head_q;
  assign bus.head_valid    = valid_q[head_q];
  assign bus.head_ready    = head_ready_w;
  assign bus.head_wr_mem   = valid_q[head_q] & wr_mem_q[head_q];
  assign bus.head_dest_reg = valid_q[head_q] ? dest_q[head_q]  : '0;
  assign bus.head_value    = valid_q[head_q] ? value_q[head_q] : '0;
  assign bus.head_address  = valid_q[head_q] ? addr_q[head_q]  : '0;
  assign bus.read_value    = value_q[bus.read_rob_tag];
  assign bus.read_ready    = valid_q[bus.read_rob_tag] & vrdy_q[bus.read_rob_tag];

  // Number of entries strictly older than the load (modular distance from head).
  logic [TAG_W-1:0] older_w;
  logic [TAG_W-1:0] scan_idx;
  logic             base_pend;
  assign older_w = bus.load_rob_tag - head_q;

  // Base disambiguation: any older store with unknown or equal address blocks.
  always_comb begin
    base_pend = 1'b0;
    scan_idx  = head_q;
    for (int k = 0; k < ROB_SIZE; k++) begin
      scan_idx = head_q + TAG_W'(k);
      if (TAG_W'(k) < older_w && valid_q[scan_idx] && wr_mem_q[scan_idx]) begin
        if (!ardy_q[scan_idx] || addr_q[scan_idx] == bus.load_address)
          base_pend = 1'b1;
      end
    end
  end

`ifdef ROB_STORE_FWD_EN
  logic             fwd_ok;
  logic [XW-1:0]    fwd_val;
  logic [TAG_W-1:0] fwd_idx;

  // Oldest-to-youngest scan: a match arms forwarding, an unknown address after it disarms.
  always_comb begin
    fwd_ok  = 1'b0;
    fwd_val = '0;
    fwd_idx = head_q;
    for (int k = 0; k < ROB_SIZE; k++) begin
      fwd_idx = head_q + TAG_W'(k);
      if (TAG_W'(k) < older_w && valid_q[fwd_idx] && wr_mem_q[fwd_idx]) begin
        if (ardy_q[fwd_idx] && addr_q[fwd_idx] == bus.load_address) begin
          fwd_ok  = vrdy_q[fwd_idx];
          fwd_val = value_q[fwd_idx];
        end else if (!ardy_q[fwd_idx]) begin
          fwd_ok = 1'b0;
        end
      end
    end
  end

  assign bus.fwd_hit        = fwd_ok;
  assign bus.fwd_value      = fwd_ok ? fwd_val : '0;
  assign bus.pending_stores = base_pend & ~fwd_ok;
`else
  assign bus.fwd_hit        = 1'b0;
  assign bus.fwd_value      = '0;
  assign bus.pending_stores = base_pend;
`endif

endmodule

// File: tb/tb_rob_multi.sv
// tb_rob_multi: directed and randomized bench for rob_multi. A queue-based
// age-ordered model predicts every output each cycle; a separate monitor
// process pops the predictions and compares them against the DUT.
`ifndef XLEN
`define XLEN 32
`endif

module tb_rob_multi;
  localparam int SIZE  = 8;
  localparam int PORTS = 2;
  localparam int TW    = 3;
  localparam int XW    = `XLEN;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  rob_multi_if #(.ROB_SIZE(SIZE), .CDB_PORTS(PORTS)) bus ();
  rob_multi #(.ROB_SIZE(SIZE), .CDB_PORTS(PORTS)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int            tag;
    bit            wr;
    logic [4:0]    dest;
    logic [XW-1:0] val;
    bit            vrdy;
    logic [XW-1:0] addr;
    bit            ardy;
    int            dep;
  } ent_t;

  typedef struct {
    logic [TW:0]   count;
    logic          full, empty;
    logic [TW-1:0] slot, htag;
    logic          hvalid, hready, hwr;
    logic [4:0]    hdest;
    logic [XW-1:0] hval, haddr;
    logic          rready;
    logic [XW-1:0] rval;
    logic          pend, fhit;
    logic [XW-1:0] fval;
  } exp_t;

  ent_t mq[$];      // valid entries, oldest first
  int   mhead = 0;
  exp_t exp_q[$];
  event sample_ev;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Expected outputs for the current model state and current inputs.
  function automatic exp_t model_out();
    exp_t x;
    int n, older, src;
    bit ok;
    n = mq.size();
    x.count = (TW+1)'(n);
    x.full  = (n == SIZE);
    x.empty = (n == 0);
    x.slot  = TW'((mhead + n) % SIZE);
    x.htag  = TW'(mhead);
    x.hvalid = (n > 0);
    x.hready = 0; x.hwr = 0; x.hdest = '0; x.hval = '0; x.haddr = '0;
    if (n > 0) begin
      x.hready = mq[0].vrdy && mq[0].ardy;
      x.hwr    = mq[0].wr;
      x.hdest  = mq[0].dest;
      x.hval   = mq[0].val;
      x.haddr  = mq[0].addr;
    end
    x.rready = 0; x.rval = '0;
    foreach (mq[i]) begin
      if (mq[i].tag == int'(bus.read_rob_tag)) begin
        x.rready = mq[i].vrdy;
        x.rval   = mq[i].val;
      end
    end
    older = (int'(bus.load_rob_tag) - mhead + SIZE) % SIZE;
    if (older > n) older = n;
    x.pend = 0; x.fhit = 0; x.fval = '0;
    for (int i = 0; i < older; i++)
      if (mq[i].wr && (!mq[i].ardy || mq[i].addr == bus.load_address)) x.pend = 1;
`ifdef ROB_STORE_FWD_EN
    src = -1;
    for (int i = 0; i < older; i++)
      if (mq[i].wr && mq[i].ardy && mq[i].addr == bus.load_address) src = i;
    if (src >= 0 && mq[src].vrdy) begin
      ok = 1;
      for (int j = src + 1; j < older; j++) if (mq[j].wr && !mq[j].ardy) ok = 0;
      if (ok) begin
        x.fhit = 1; x.fval = mq[src].val; x.pend = 0;
      end
    end
`else
    src = -1; ok = 0;
    if (src > 0 || ok) x.fhit = 0;
`endif
    return x;
  endfunction

  // Advance the model by one clock edge using the current inputs.
  function automatic void model_step();
    int n, t;
    bit do_alloc, do_commit, vr0;
    logic [XW-1:0] d;
    ent_t ne;
    n = mq.size();
    if (bus.flush) begin
      mq.delete();
      mhead = 0;
      return;
    end
    do_alloc  = bus.alloc_enable && (n < SIZE);
    do_commit = bus.commit_enable && (n > 0) && mq[0].vrdy && mq[0].ardy;
    ne = '{tag: (mhead + n) % SIZE, wr: bus.alloc_wr_mem, dest: bus.alloc_dest_reg,
           val: '0, vrdy: 0, addr: '0, ardy: !bus.alloc_wr_mem,
           dep: int'(bus.alloc_store_dep)};
    if (bus.alloc_wr_mem) begin
      if (bus.alloc_value_in_valid) begin
        ne.val = bus.alloc_value_in; ne.vrdy = 1;
      end else begin
        for (int p = 0; p < PORTS; p++)
          if (bus.cdb_valid[p] && int'(bus.cdb_tag[p*TW +: TW]) == ne.dep) begin
            ne.val = bus.cdb_value[p*XW +: XW]; ne.vrdy = 1;
          end
      end
    end
    foreach (mq[i]) begin
      vr0 = mq[i].vrdy;
      for (int p = 0; p < PORTS; p++) begin
        if (bus.cdb_valid[p]) begin
          t = int'(bus.cdb_tag[p*TW +: TW]);
          d = bus.cdb_value[p*XW +: XW];
          if (t == mq[i].tag) begin
            if (mq[i].wr) begin mq[i].addr = d; mq[i].ardy = 1; end
            else begin mq[i].val = d; mq[i].vrdy = 1; end
          end
          if (mq[i].wr && !vr0 && t == mq[i].dep) begin
            mq[i].val = d; mq[i].vrdy = 1;
          end
        end
      end
    end
    if (do_commit) begin
      void'(mq.pop_front());
      mhead = (mhead + 1) % SIZE;
    end
    if (do_alloc) mq.push_back(ne);
  endfunction

  // Called in the low clock phase after inputs are set: predict, then clock.
  task automatic step();
    exp_q.push_back(model_out());
    -> sample_ev;
    model_step();
    @(negedge clock);
  endtask

  // Monitor: compare each prediction against the DUT shortly after it is issued.
  initial begin
    exp_t e;
    forever begin
      @(sample_ev);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("count",        64'(bus.count),         64'(e.count));
        chk("full",         64'(bus.full),          64'(e.full));
        chk("empty",        64'(bus.empty),         64'(e.empty));
        chk("alloc_slot",   64'(bus.alloc_slot),    64'(e.slot));
        chk("head_tag",     64'(bus.head_tag),      64'(e.htag));
        chk("head_valid",   64'(bus.head_valid),    64'(e.hvalid));
        chk("head_ready",   64'(bus.head_ready),    64'(e.hready));
        chk("head_wr_mem",  64'(bus.head_wr_mem),   64'(e.hwr));
        chk("head_dest",    64'(bus.head_dest_reg), 64'(e.hdest));
        chk("head_value",   64'(bus.head_value),    64'(e.hval));
        chk("head_address", 64'(bus.head_address),  64'(e.haddr));
        chk("read_ready",   64'(bus.read_ready),    64'(e.rready));
        if (e.rready) chk("read_value", 64'(bus.read_value), 64'(e.rval));
        chk("pending",      64'(bus.pending_stores), 64'(e.pend));
        chk("fwd_hit",      64'(bus.fwd_hit),       64'(e.fhit));
        chk("fwd_value",    64'(bus.fwd_value),     64'(e.fval));
      end
    end
  end

  task automatic idle();
    bus.alloc_enable = 0; bus.alloc_wr_mem = 0; bus.alloc_dest_reg = '0;
    bus.alloc_value_in = '0; bus.alloc_value_in_valid = 0; bus.alloc_store_dep = '0;
    bus.cdb_valid = '0; bus.cdb_tag = '0; bus.cdb_value = '0;
    bus.commit_enable = 0; bus.flush = 0;
    bus.read_rob_tag = '0; bus.load_address = '0; bus.load_rob_tag = '0;
  endtask

  task automatic set_alloc(input bit wr, input logic [4:0] dest, input bit vv,
                           input logic [XW-1:0] v, input int dep);
    bus.alloc_enable = 1; bus.alloc_wr_mem = wr; bus.alloc_dest_reg = dest;
    bus.alloc_value_in_valid = vv; bus.alloc_value_in = v;
    bus.alloc_store_dep = TW'(dep);
  endtask

  task automatic cdb(input int p, input int tag, input logic [XW-1:0] v);
    bus.cdb_valid[p] = 1'b1;
    bus.cdb_tag[p*TW +: TW] = TW'(tag);
    bus.cdb_value[p*XW +: XW] = v;
  endtask

  function automatic logic [XW-1:0] pick();
    case ($urandom_range(0, 3))
      0: return XW'(32'h10);
      1: return XW'(32'h20);
      2: return XW'(32'h30);
      default: return XW'($urandom());
    endcase
  endfunction

  task automatic randomize_inputs();
    idle();
    bus.alloc_enable = 1'($urandom_range(0, 1));
    bus.alloc_wr_mem = ($urandom_range(0, 2) == 0);
    bus.alloc_dest_reg = 5'($urandom_range(0, 31));
    bus.alloc_value_in = pick();
    bus.alloc_value_in_valid = 1'($urandom_range(0, 1));
    bus.alloc_store_dep = TW'($urandom_range(0, SIZE - 1));
    for (int p = 0; p < PORTS; p++)
      if ($urandom_range(0, 2) != 0) cdb(p, int'($urandom_range(0, SIZE - 1)), pick());
    bus.commit_enable = ($urandom_range(0, 2) != 0);
    bus.flush = ($urandom_range(0, 99) == 0);
    bus.read_rob_tag = TW'($urandom_range(0, SIZE - 1));
    bus.load_rob_tag = TW'($urandom_range(0, SIZE - 1));
    bus.load_address = pick();
  endtask

  initial begin
    idle();
    repeat (2) @(negedge clock);
    // Reset state
    chk("rst_empty",      64'(bus.empty), 64'(1));
    chk("rst_count",      64'(bus.count), 64'(0));
    chk("rst_full",       64'(bus.full), 64'(0));
    chk("rst_slot",       64'(bus.alloc_slot), 64'(0));
    chk("rst_head_valid", 64'(bus.head_valid), 64'(0));
    chk("rst_pending",    64'(bus.pending_stores), 64'(0));
    chk("rst_fwd_hit",    64'(bus.fwd_hit), 64'(0));
    chk("rst_read_ready", 64'(bus.read_ready), 64'(0));
    chk("rst_read_value", 64'(bus.read_value), 64'(0));
    reset = 1;
    mq.delete(); mhead = 0;
    @(negedge clock);

    // Fill to capacity, then one ignored allocation
    for (int i = 0; i < SIZE; i++) begin
      idle(); set_alloc(0, 5'(i + 1), 0, '0, 0); step();
    end
    chk("fill_full",  64'(bus.full), 64'(1));
    chk("fill_count", 64'(bus.count), 64'(8));
    chk("fill_slot",  64'(bus.alloc_slot), 64'(0));
    idle(); set_alloc(0, 5'd9, 0, '0, 0); bus.commit_enable = 1; step();
    chk("ninth_count", 64'(bus.count), 64'(8));

    // Two ports, two tags; then same tag on both ports
    idle(); cdb(0, 2, 32'h22); cdb(1, 5, 32'h55); step();
    idle(); bus.read_rob_tag = 3'd2; #1;
    chk("p0_ready", 64'(bus.read_ready), 64'(1));
    chk("p0_value", 64'(bus.read_value), 64'(32'h22));
    step();
    idle(); bus.read_rob_tag = 3'd5; #1;
    chk("p1_value", 64'(bus.read_value), 64'(32'h55));
    step();
    idle(); cdb(0, 3, 32'd7); cdb(1, 3, 32'd9); step();
    idle(); bus.read_rob_tag = 3'd3; #1;
    chk("dup_tag_value", 64'(bus.read_value), 64'(9));
    step();
    idle(); bus.flush = 1; step();
    chk("flush8_empty", 64'(bus.empty), 64'(1));

    // Disambiguation: store at tag 1, load at tag 3
    idle(); set_alloc(0, 5'd1, 0, '0, 0); step();
    idle(); set_alloc(1, 5'd0, 1, 32'h55, 0); step();
    idle(); set_alloc(0, 5'd2, 0, '0, 0); step();
    idle(); set_alloc(0, 5'd3, 0, '0, 0); step();
    idle(); bus.load_rob_tag = 3'd3; bus.load_address = 32'h20; #1;
    chk("unk_addr_pending", 64'(bus.pending_stores), 64'(1));
    step();
    idle(); cdb(0, 1, 32'h10); bus.load_rob_tag = 3'd3; bus.load_address = 32'h20; step();
    idle(); bus.load_rob_tag = 3'd3; bus.load_address = 32'h20; #1;
    chk("diff_addr_pending", 64'(bus.pending_stores), 64'(0));
    step();
    idle(); bus.load_rob_tag = 3'd3; bus.load_address = 32'h10; #1;
`ifdef ROB_STORE_FWD_EN
    chk("fwd_hit_on",  64'(bus.fwd_hit), 64'(1));
    chk("fwd_value",   64'(bus.fwd_value), 64'(32'h55));
    chk("fwd_pending", 64'(bus.pending_stores), 64'(0));
`else
    chk("same_addr_pending", 64'(bus.pending_stores), 64'(1));
    chk("fwd_hit_off",       64'(bus.fwd_hit), 64'(0));
`endif
    step();

    // Commit and allocate together at count 4
    idle(); cdb(0, 0, 32'hA0); cdb(1, 2, 32'hA2); step();
    idle(); cdb(0, 3, 32'hA3); step();
    chk("pre_commit_count", 64'(bus.count), 64'(4));
    idle(); bus.commit_enable = 1; set_alloc(0, 5'd4, 0, '0, 0); step();
    chk("cmt_alloc_count", 64'(bus.count), 64'(4));
    chk("cmt_alloc_head",  64'(bus.head_tag), 64'(1));
    idle(); set_alloc(0, 5'd5, 0, '0, 0); step();
    chk("five_count", 64'(bus.count), 64'(5));
    idle(); bus.flush = 1; set_alloc(0, 5'd6, 0, '0, 0); step();
    chk("flush5_empty", 64'(bus.empty), 64'(1));
    chk("flush5_slot",  64'(bus.alloc_slot), 64'(0));

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      randomize_inputs(); step();
    end

    // Asynchronous reset with three valid entries
    idle(); bus.flush = 1; step();
    for (int i = 0; i < 3; i++) begin
      idle(); set_alloc(0, 5'(i + 1), 0, '0, 0); step();
    end
    chk("pre_rst_count", 64'(bus.count), 64'(3));
    idle(); set_alloc(0, 5'd7, 0, '0, 0);
    #2 reset = 0;
    #1;
    chk("async_rst_empty", 64'(bus.empty), 64'(1));
    chk("async_rst_count", 64'(bus.count), 64'(0));
    repeat (2) @(negedge clock);
    chk("held_rst_empty", 64'(bus.empty), 64'(1));
    idle();
    #2 reset = 1;
    mq.delete(); mhead = 0;
    #1;
    chk("release_empty", 64'(bus.empty), 64'(1));
    step();
    step();

    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rob_multi.md
# rob_multi

Parametrised reorder buffer, successor to the single-CDB ROB. It supports configurable depth and multiple CDB write ports, and adds explicit commit and flush handshakes. Older-store disambiguation is kept, and optional store-to-load forwarding is new. It sits between dispatch (allocation), the CDB (completion), the load unit (disambiguation query) and the commit stage (head pop).

## Interface
- ROB_SIZE, 8, entry count; power of two, ≥2; TAG_W = $clog2(ROB_SIZE)
- CDB_PORTS, 2, number of CDB broadcast ports, ≥1
- `clock` in 1: single clock, rising edge.
- `reset` in 1: reset is asynchronous and active-low. 0 clears all state immediately.
- `alloc_enable` in 1: request to allocate the tail entry.
- `alloc_wr_mem` in 1: the new instruction is a store.
- `alloc_dest_reg` in 5: architectural destination (0 = none).
- `alloc_value_in` in `XLEN`: store data, if already available.
- `alloc_value_in_valid` in 1: alloc_value_in is valid.
- `alloc_store_dep` in TAG_W: tag producing the store data when it is not valid.
- `cdb_valid` in CDB_PORTS: per-port broadcast valid.
- `cdb_tag` in CDB_PORTS*TAG_W: per-port tag, port i at [i*TAG_W +: TAG_W].
- `cdb_value` in CDB_PORTS*`XLEN`: per-port result, or address for store entries.
- `commit_enable` in 1: commit stage pops the head.
- `flush` in 1: discard all entries.
- `read_rob_tag` in TAG_W; `read_value` out `XLEN`; `read_ready` out 1: operand read port.
- `load_address` in `XLEN`; `load_rob_tag` in TAG_W: disambiguation query.
- `pending_stores` out 1: the load must wait.
- `fwd_hit` out 1; `fwd_value` out `XLEN`: forwarding result (tied 0 without the macro).
- `full`, `empty` out 1; `count` out TAG_W+1; `alloc_slot` out TAG_W.
- `head_valid`, `head_ready`, `head_wr_mem` out 1; `head_dest_reg` out 5; `head_value`, `head_address` out `XLEN`; `head_tag` out TAG_W.

## Operation
- Each entry holds: valid, wr_mem, dest_reg, value, value_ready, address, address_ready, store_dep.
- Non-store entries have address_ready = 1 at allocation.
- Circular buffer with head/tail pointers of TAG_W bits, wrapping modulo ROB_SIZE. `count` is tracked separately.
- alloc_slot = tail.
- Allocation: alloc_enable && !full writes the tail entry and advances tail. Allocation while full is ignored, even if commit happens the same cycle.
- Store data bypass at allocation: if !alloc_value_in_valid and a CDB port broadcasts alloc_store_dep in the same cycle, the value is captured and value_ready = 1.
- CDB write, per valid port:
  - Non-store entry whose tag matches: value ← data, value_ready ← 1.
  - Store entry whose own tag matches: address ← data, address_ready ← 1.
  - Store entry with !value_ready whose store_dep matches: value ← data, value_ready ← 1.
  - If several ports carry the same tag, the highest port index wins.
  - Broadcasts to invalid entries are ignored.
- Readiness: head_ready = head_valid && value_ready && address_ready.
- Commit: commit_enable && head_ready invalidates the head and advances it. commit_enable without head_ready is ignored.
- Flush: highest priority over alloc, commit and CDB. Next cycle: all entries invalid, head = tail = 0, count = 0.
- Read port: read_value and read_ready come combinationally from entry[read_rob_tag]. read_ready = valid && value_ready.
- Disambiguation: scan the valid store entries strictly older than load_rob_tag, from head up to load_rob_tag exclusive, with wrap handled.
  - pending_stores = 1 if any such store has !address_ready, or has address == load_address.
  - pending_stores = 0 if load_rob_tag == head.

## Timing
- Outputs after reset: full 0, empty 1, count 0, alloc_slot 0, head_* 0, pending_stores 0, read_* 0, fwd_* 0.
- Allocation, CDB writes, commit and flush all take effect at the next rising edge.
- head_ready, pending_stores and read_ready rise in the cycle after the CDB broadcast.
- head_*, full, empty, count, alloc_slot, read_* and pending_stores are combinational from registered state. There is no same-cycle CDB bypass to these outputs.
- Allocate and commit in the same cycle (not full): count is unchanged and both pointers advance.
- A broadcast to the tag being allocated in that same cycle is not captured.
- Reset asserted mid-operation clears state asynchronously. Inputs are ignored while reset = 0.

## Configuration
- `ROB_STORE_FWD_EN` defined: store-to-load forwarding is enabled.
  - Find the youngest older store with address_ready and a matching address.
  - If that store has value_ready, and every store between it and the load has address_ready, then: fwd_hit = 1, fwd_value = that store's value, pending_stores = 0.
  - Otherwise the disambiguation rules above apply.
- `ROB_STORE_FWD_EN` undefined: fwd_hit = 0 and fwd_value = 0. pending_stores follows the base rule only.

## Test plan
- Reset, then 8 allocations with ROB_SIZE = 8: full = 1 after the 8th, count = 8, alloc_slot wraps to 0. A 9th allocation is ignored.
- Broadcast tags 2 and 5 on ports 0 and 1 in the same cycle: both entries are value_ready next cycle. Same tag on both ports with values 7 and 9: 9 is stored.
- Store at tag 1 with address unknown, load at tag 3: pending_stores = 1. After CDB sends tag 1 with address 0x10 and load_address = 0x20: pending_stores = 0.
- With `ROB_STORE_FWD_EN`: store at tag 1 with address 0x10 and data 0x55, load at tag 2 with address 0x10: fwd_hit = 1, fwd_value = 0x55, pending_stores = 0. Without the macro: pending_stores = 1, fwd_hit = 0.
- Commit head while allocating in the same cycle at count 4: count stays 4 and head_tag increments. Flush with 5 valid entries: next cycle empty = 1, alloc_slot = 0.
- Drop reset to 0 mid-stream with 3 entries valid: empty = 1 immediately, and it stays empty through the release of reset.
